// File: rtl/wam_pkg.sv
// -----------------------------------------------------------------------------
// wam_pkg
// Shared definitions for the button-conditioning front end of the game FSM.
//   NUM_BTN_DEF  : default number of button channels
//   DEBOUNCE_DEF : default number of stable synchronised samples per change
//   CNT_W_DEF    : default debounce counter width
//   STUCK_DEF    : default hold length that flags a stuck button
//   HOLD_W       : width of the optional stuck-detection hold counter
//   btn_vec_t    : one bit per button channel
//   deb_evt_e    : debouncer event raised on the edge that updates 'stable'
// -----------------------------------------------------------------------------
package wam_pkg;

  localparam int unsigned NUM_BTN_DEF  = 8;
  localparam int unsigned DEBOUNCE_DEF = 4;
  localparam int unsigned CNT_W_DEF    = 8;
  localparam int unsigned STUCK_DEF    = 60000;
  localparam int unsigned HOLD_W       = 16;

  typedef logic [NUM_BTN_DEF-1:0] btn_vec_t;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_RISE = 2'd1,
    EV_FALL = 2'd2
  } deb_evt_e;

endpackage : wam_pkg

// File: rtl/btn_debounce_ch.sv
// -----------------------------------------------------------------------------
// btn_debounce_ch
// One button channel: 2-FF synchroniser, counter debouncer and lockout-aware
// qualification producing a held level plus one-cycle press/release pulses.
// Optional stuck-button detection is built when BTN_STUCK_DET_EN is defined.
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   enable_i     press qualification enable
//   btn_raw_i    asynchronous raw button, active-high
//   lockout_i    lockout for this channel, synchronous to clk_i
//   btn_level_o  qualified debounced held level (registered)
//   btn_press_o  one-cycle pulse on a qualified press (registered)
//   btn_release_o one-cycle pulse when a qualified button is released
//   stuck_o      stuck flag; constant 0 without BTN_STUCK_DET_EN
// -----------------------------------------------------------------------------
module btn_debounce_ch
  import wam_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF,
  parameter int unsigned STUCK_CYCLES    = STUCK_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic btn_raw_i,
  input  logic lockout_i,
  output logic btn_level_o,
  output logic btn_press_o,
  output logic btn_release_o,
  output logic stuck_o
);

  // Elaboration-time parameter legality checks.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("btn_debounce_ch: DEBOUNCE_CYCLES must be within 2..255");
  end
  if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
    $error("btn_debounce_ch: CNT_W too narrow for DEBOUNCE_CYCLES");
  end
  if (STUCK_CYCLES < 1 || STUCK_CYCLES >= (1 << HOLD_W)) begin : g_bad_stuck
    $error("btn_debounce_ch: STUCK_CYCLES must fit the hold counter");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             qual_q, qual_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  deb_evt_e         evt;
  logic             stuck_w;

  // Debounce: any disagreement between s2 and stable must persist for
  // DEBOUNCE_CYCLES consecutive samples; a single agreeing sample restarts it.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    evt      = EV_NONE;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = s2_q;
      cnt_d    = '0;
      evt      = s2_q ? EV_RISE : EV_FALL;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Qualification: lockout (or a stuck hold) kills the level silently; a
  // release pulse is only emitted for a channel that was qualified.
  always_comb begin
    qual_d    = qual_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (lockout_i || stuck_w) begin
      qual_d = 1'b0;
    end else if (evt == EV_FALL) begin
      qual_d    = 1'b0;
      release_d = qual_q;
    end else if (evt == EV_RISE && enable_i) begin
      qual_d  = 1'b1;
      press_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      qual_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= btn_raw_i;
      s2_q      <= s1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      qual_q    <= qual_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef BTN_STUCK_DET_EN
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(STUCK_CYCLES);

  logic [HOLD_W-1:0] hold_q, hold_d;

  // Hold counter saturates at HOLD_MAX and clears one edge after stable falls.
  always_comb begin
    hold_d = hold_q;
    if (!stable_q) begin
      hold_d = '0;
    end else if (hold_q != HOLD_MAX) begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign stuck_w = (hold_q == HOLD_MAX);
`else
  assign stuck_w = 1'b0;
`endif

  assign btn_level_o   = qual_q;
  assign btn_press_o   = press_q;
  assign btn_release_o = release_q;
  assign stuck_o       = stuck_w;

endmodule : btn_debounce_ch

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
// Conditions NUM_BTN raw asynchronous buttons for the game FSM: synchronise,
// debounce, apply the FSM's lockout mask and the enable, and produce held
// levels, press/release pulses and an any-press strobe.
// Optional feature macro: BTN_STUCK_DET_EN (per-channel stuck-button flags).
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   enable      press qualification enable (ena & ~game_end)
//   btn_raw     raw asynchronous buttons, active-high
//   lockout     per-channel lockout mask from the FSM
//   btn_level   qualified debounced held level (FSM btn_sync input)
//   btn_press   one-cycle pulse per qualified press
//   btn_release one-cycle pulse per qualified release
//   any_press   OR of btn_press, aligned with btn_press
//   stuck       stuck-button flags; 0 without BTN_STUCK_DET_EN
// -----------------------------------------------------------------------------
module btn_conditioner
  import wam_pkg::*;
#(
  parameter int unsigned NUM_BTN         = NUM_BTN_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF,
  parameter int unsigned STUCK_CYCLES    = STUCK_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_BTN-1:0] lockout,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               any_press,
  output logic [NUM_BTN-1:0] stuck
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_ch (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .enable_i      (enable),
      .btn_raw_i     (btn_raw[i]),
      .lockout_i     (lockout[i]),
      .btn_level_o   (btn_level[i]),
      .btn_press_o   (btn_press[i]),
      .btn_release_o (btn_release[i]),
      .stuck_o       (stuck[i])
    );
  end

  // btn_press is already registered, so the OR lands in the same cycle.
  assign any_press = |btn_press;

endmodule : btn_conditioner

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Upstream stage of the game FSM; replaces the raw `ui_in & ~lockout` button path.
- Per channel: 2-FF synchroniser, then counter-based debouncer, then lockout-aware qualification.
- Produces a qualified held level, one-cycle press/release pulses and an any-press strobe.
- The game FSM consumes `btn_level` as its `btn_sync` input and feeds its `lockout` register back here.

Parameters:
- NUM_BTN, 8: number of button channels.
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required before a state change; legal range 2..255.
- CNT_W, 8: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- STUCK_CYCLES, 60000: hold length that flags a stuck button; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  pulse qualification enable; FSM drives it as `ena & ~game_end`.
- btn_raw  in  NUM_BTN  asynchronous raw buttons, active-high.
- lockout  in  NUM_BTN  per-channel lockout mask from the FSM, synchronous to clk.
- btn_level  out  NUM_BTN  qualified debounced held level.
- btn_press  out  NUM_BTN  one-cycle pulse on a qualified press.
- btn_release  out  NUM_BTN  one-cycle pulse when a qualified button is released.
- any_press  out  1  OR of btn_press, registered in the same cycle as btn_press.
- stuck  out  NUM_BTN  stuck-button flags; tied to 0 without the optional feature.

Behaviour:
- Reset, asynchronous: s1, s2, stable, qual, cnt, all outputs = 0. Reset is effective mid-debounce; no pulse is emitted on reset exit.
- Sync stage: s1 <= btn_raw; s2 <= s1.
- Debounce, per channel, every edge:
  - if s2 == stable: cnt <= 0;
  - else if cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0;
  - else cnt <= cnt+1.
- A glitch shorter than DEBOUNCE_CYCLES samples resets cnt and never changes stable.
- Latency: raw held from edge 0 makes stable and btn_level high after edge DEBOUNCE_CYCLES+1. With the default, that is the 6th edge.
- Rising detection: rise = s2 & ~stable & (cnt == DEBOUNCE_CYCLES-1). Falling is analogous. Both are evaluated on the same edge that updates stable.
- Qualification flag qual, per channel, priority order:
  1. lockout[i] = 1: qual <= 0, no pulses.
  2. fall: qual <= 0; btn_release <= qual (a pulse only if the channel was qualified).
  3. rise & enable: qual <= 1; btn_press <= 1.
  4. otherwise qual holds.
- btn_level = qual, registered.
- btn_press and btn_release are registered pulses, exactly one cycle wide, and default to 0 each cycle.
- Lockout asserted while held: level drops on the next edge and no release pulse is emitted. Deasserting lockout while still held does NOT restore the level. The user must release and re-press.
- Rise while enable=0: stable updates, qual stays 0. Raising enable while held does not qualify the button.
- Rise and lockout on the same edge: lockout wins, no pulse.
- Channels are independent. Simultaneous rises on several channels give simultaneous pulses; any_press = 1 for one cycle.
- cnt never exceeds DEBOUNCE_CYCLES-1; there is no wrap.

Optional Feature:
- Macro: BTN_STUCK_DET_EN.
- Defined:
  - Per-channel 16-bit hold counter increments while stable=1 and saturates at STUCK_CYCLES.
  - stuck[i] = 1 when the counter equals STUCK_CYCLES.
  - The counter clears when stable=0; stuck[i] drops on the next edge.
  - A stuck channel is forced qual=0 and produces no press pulses until stable returns to 0.
- Undefined: no hold counters are built; stuck = 0; behaviour is otherwise identical.

Decomposition:
- Shared package (wam_pkg) holds:
  - constants NUM_BTN_DEF=8, DEBOUNCE_DEF=4, STUCK_DEF=60000;
  - typedef btn_vec_t (logic [NUM_BTN_DEF-1:0]).
- One natural sub-module: btn_debounce_ch, a single channel containing sync, counter, stable, qual and the optional hold counter. It is generated NUM_BTN times; the top only ORs btn_press into any_press.

Test Plan:
- Clean press, DEBOUNCE_CYCLES=4: btn_raw[2] 0->1 held, lockout=0, enable=1 -> btn_level[2] = 1 after edge 6; btn_press = 8'h04 for exactly 1 cycle; any_press pulses once. Release -> btn_release = 8'h04 pulse after 6 edges.
- Glitches: btn_raw[0] high for 3 cycles then low, repeated 5 times -> btn_level, btn_press and btn_release stay 0 throughout.
- Lockout mid-hold: hold btn[1], assert lockout = 8'h02 at cycle 20 -> level 0 from cycle 21, no release pulse. Deassert at cycle 30 while still held -> level stays 0. Release and re-press -> new press pulse.
- Enable gating: enable=0, press btn[5] -> no pulse, level 0. Set enable=1 while held -> still 0. Release and re-press -> pulse 8'h20.
- Simultaneous and reset: press btn[0] and btn[6] in the same cycle -> btn_press = 8'h41 in one cycle. Assert rst_n=0 mid-debounce of btn[3] -> all outputs 0 immediately; after release of reset with raw held -> press after 6 edges.
- With BTN_STUCK_DET_EN and STUCK_CYCLES=20: hold btn[4] -> stuck[4] = 1 and level 0 after about 26 edges. Release -> stuck[4] = 0 after the debounce plus 1 edge.
